axil_slave_regs: RTL and testbench
==================================

Name: axil_slave_regs

Overview:
- AXI4-Lite responder: a memory-mapped bank of NUM_REGS 32-bit read/write registers.
- Connects to the slave end of the team's AXI4-Lite interface and serves as the target for master/interconnect verification.
- Read and write paths are independent FSMs, so one read and one write can be outstanding concurrently.

Parameters:
ADDR_WIDTH, 32, width of araddr/awaddr (matches addr_t)
DATA_WIDTH, 32, width of rdata/wdata (matches data_t); wstrb width is DATA_WIDTH/8
NUM_REGS, 32, number of registers; must be a power of 2, 2..256

Ports:
aclk  in  1  clock; all logic on rising edge
areset_n  in  1  asynchronous active-low reset
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response: 00 OKAY, 10 SLVERR
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response: 00 OKAY, 10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset:
  - Asynchronous, active-low: areset_n is asserted asynchronously and released synchronously to aclk by the system.
  - While areset_n=0: all outputs are 0 and all registers are 0.
  - arready, awready and wready go to 1 on the first aclk edge after release.
  - Reset asserted mid-transaction aborts it; no register is modified by an incomplete write.
- Decode:
  - Word index = addr[log2(NUM_REGS)+1:2].
  - An address is in range when addr < NUM_REGS*4. Out-of-range accesses get SLVERR, rdata=0, and no register write.
- Read FSM:
  - R_IDLE (arready=1): on arvalid&arready, latch data/resp from the decoded register, go to R_RESP. In R_RESP, arready=0 and rvalid=1.
  - R_RESP: rvalid, rdata and rresp are held stable until rvalid&rready, then go to R_IDLE (rvalid=0, arready=1).
  - Latency: rvalid asserts 1 cycle after the AR handshake. Throughput: 1 read per 2 cycles when rready is held high.
- Write FSM:
  - W_IDLE: awready=1 and wready=1. AW and W are captured independently in either order or in the same cycle; each channel's ready drops after its own handshake.
  - When both are captured: commit the write and go to W_RESP with bvalid=1, on the edge after the later handshake.
  - Commit: byte i of the register is updated only where wstrb[i]=1. wstrb=0 yields OKAY with no change.
  - W_RESP: bvalid and bresp are held until bvalid&bready, then go to W_IDLE with awready=wready=1.
  - A second AW or W is never accepted before B completes.
- Read/write collision: if a read handshake and a write commit hit the same register on the same edge, rdata returns the pre-write value.
- Sub-word address bits (addr[1:0]) are ignored; see Optional Feature for the alternative.

Optional Feature:
- Macro: AXIL_SLAVE_UNALIGNED_ERR_EN.
- Defined: any access with addr[1:0]!=0 returns SLVERR. Writes are dropped and reads return rdata=0.
- Undefined: addr[1:0] are ignored and the access proceeds as word-aligned.

Test Plan:
- Reset, then write 0x0000_0008 data 0xDEADBEEF strb 0xF, then read 0x8 -> bresp=00; rdata=0xDEADBEEF, rresp=00, rvalid 1 cycle after the AR handshake.
- Starting from reg[1]=0xDEADBEEF: write 0x4 data 0x11223344 strb 0x5 -> reg[1]=0xDE22BE44.
- W channel presented 3 cycles before AW at 0xC -> wready drops after the W handshake; bvalid rises exactly 1 cycle after the AW handshake; reg[3] updated.
- Read 0x80 with NUM_REGS=32 -> rresp=10, rdata=0; write 0x80 -> bresp=10 and no register changes.
- Hold rready=0 for 5 cycles after rvalid -> rdata/rresp stable, arready=0 throughout; with bready=0, bvalid stays high and awready=0.
- Pulse areset_n low while in W_RESP -> bvalid=0 immediately and register contents are 0; the first post-reset read of 0x0 returns 0x0000_0000.

Source files
------------

// File: rtl/axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axil_slave_regs
// Purpose  : AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers
//            with independent read and write state machines.
// Option   : define AXIL_SLAVE_UNALIGNED_ERR_EN to reject addr[1:0] != 0
// Revision : 1.0 - initial release
// ============================================================================
module axil_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_t;
    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;

    rstate_t                 r_rstate;
    wstate_t                 r_wstate;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic                    r_aw_got;
    logic                    r_w_got;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;

    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
`ifdef AXIL_SLAVE_UNALIGNED_ERR_EN
        return (a >= C_ADDR_LIMIT) || (a[1:0] != 2'b00);
`else
        return (a >= C_ADDR_LIMIT);
`endif
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    logic                    w_ar_hs;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_aw_have;
    logic                    w_w_have;
    logic [ADDR_WIDTH-1:0]   w_cmt_addr;
    logic [DATA_WIDTH-1:0]   w_cmt_data;
    logic [STRB_W-1:0]       w_cmt_strb;
    logic                    w_cmt_err;

    assign w_ar_hs    = arvalid && arready;
    assign w_aw_hs    = awvalid && awready;
    assign w_w_hs     = wvalid && wready;
    assign w_aw_have  = r_aw_got || w_aw_hs;
    assign w_w_have   = r_w_got || w_w_hs;
    // A channel captured in an earlier cycle comes from the holding register,
    // otherwise the live bus value is committed directly.
    assign w_cmt_addr = r_aw_got ? r_awaddr : awaddr;
    assign w_cmt_data = r_w_got ? r_wdata : wdata;
    assign w_cmt_strb = r_w_got ? r_wstrb : wstrb;
    assign w_cmt_err  = addr_err(w_cmt_addr);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_rstate <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= C_RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (w_ar_hs) begin
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        r_rstate <= R_RESP;
                        // Sampling the array here returns the pre-write value
                        // when a write commits to the same word on this edge.
                        if (addr_err(araddr)) begin
                            rdata <= '0;
                            rresp <= C_RESP_SLVERR;
                        end else begin
                            rdata <= r_regs[addr_idx(araddr)];
                            rresp <= C_RESP_OKAY;
                        end
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_wstate <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= C_RESP_OKAY;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_have && w_w_have) begin
                        if (!w_cmt_err) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (w_cmt_strb[b]) begin
                                    r_regs[addr_idx(w_cmt_addr)][b*8 +: 8] <= w_cmt_data[b*8 +: 8];
                                end
                            end
                        end
                        bresp    <= w_cmt_err ? C_RESP_SLVERR : C_RESP_OKAY;
                        bvalid   <= 1'b1;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                        r_wstate <= W_RESP;
                    end else begin
                        awready <= !w_aw_have;
                        wready  <= !w_w_have;
                        if (w_aw_hs) begin
                            r_aw_got <= 1'b1;
                            r_awaddr <= awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_got <= 1'b1;
                            r_wdata <= wdata;
                            r_wstrb <= wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        bresp    <= C_RESP_OKAY;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_slave_regs
// Purpose  : Directed self-checking bench for axil_slave_regs (NUM_REGS=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_slave_regs;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axil_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after both handshakes.
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_hs;
        logic w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge aclk);
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        chk("aw_w_accept", {30'b0, awvalid, wvalid}, 32'h0);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp);
        int n = 0;
        while (!bvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("bvalid_seen", {31'b0, bvalid}, 32'h1);
        resp = bresp;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        send_aw_w(a, d, s);
        get_b(resp);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("arready_seen", {31'b0, arready}, 32'h1);
        @(negedge aclk);
        arvalid = 1'b0;
        chk("rvalid_latency", {31'b0, rvalid}, 32'h1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        areset_n = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

        repeat (3) @(negedge aclk);
        chk("rst_arready", {31'b0, arready}, 32'h0);
        chk("rst_awready", {31'b0, awready}, 32'h0);
        chk("rst_wready",  {31'b0, wready},  32'h0);
        chk("rst_rvalid",  {31'b0, rvalid},  32'h0);
        chk("rst_bvalid",  {31'b0, bvalid},  32'h0);
        chk("rst_rdata",   rdata, 32'h0);
        areset_n = 1'b1;
        @(negedge aclk);
        chk("post_rst_arready", {31'b0, arready}, 32'h1);
        chk("post_rst_awready", {31'b0, awready}, 32'h1);
        chk("post_rst_wready",  {31'b0, wready},  32'h1);

        // Basic write then read-back
        do_write(32'h8, 32'hDEADBEEF, 4'hF, r);
        chk("wr8_bresp", {30'b0, r}, 32'h0);
        do_read(32'h8, d, r);
        chk("rd8_data", d, 32'hDEADBEEF);
        chk("rd8_rresp", {30'b0, r}, 32'h0);

        // Partial strobe merge
        do_write(32'h4, 32'hDEADBEEF, 4'hF, r);
        do_write(32'h4, 32'h11223344, 4'h5, r);
        chk("wr4_strb_bresp", {30'b0, r}, 32'h0);
        do_read(32'h4, d, r);
        chk("rd4_strb_data", d, 32'hDE22BE44);

        // Zero strobe: OKAY, no change
        do_write(32'h4, 32'hFFFFFFFF, 4'h0, r);
        chk("wr4_nostrb_bresp", {30'b0, r}, 32'h0);
        do_read(32'h4, d, r);
        chk("rd4_nostrb_data", d, 32'hDE22BE44);

        // W leads AW by three cycles
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        chk("wfirst_wready", {31'b0, wready}, 32'h1);
        @(negedge aclk);
        wvalid = 1'b0;
        chk("wfirst_wready_drop", {31'b0, wready}, 32'h0);
        chk("wfirst_awready_kept", {31'b0, awready}, 32'h1);
        repeat (2) @(negedge aclk);
        chk("wfirst_no_bvalid", {31'b0, bvalid}, 32'h0);
        awaddr = 32'hC; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk("wfirst_bvalid_1cyc", {31'b0, bvalid}, 32'h1);
        chk("wfirst_awready_drop", {31'b0, awready}, 32'h0);
        get_b(r);
        chk("wfirst_bresp", {30'b0, r}, 32'h0);
        do_read(32'hC, d, r);
        chk("rdC_data", d, 32'hCAFEF00D);

        // Out of range
        do_read(32'h80, d, r);
        chk("rd80_rresp", {30'b0, r}, 32'h2);
        chk("rd80_rdata", d, 32'h0);
        do_write(32'h80, 32'hFFFFFFFF, 4'hF, r);
        chk("wr80_bresp", {30'b0, r}, 32'h2);
        do_read(32'h0, d, r);
        chk("rd0_untouched", d, 32'h0);
        do_read(32'h8, d, r);
        chk("rd8_untouched", d, 32'hDEADBEEF);

        // Sub-word address bits
        do_read(32'hA, d, r);
`ifdef AXIL_SLAVE_UNALIGNED_ERR_EN
        chk("rdA_data", d, 32'h0);
        chk("rdA_rresp", {30'b0, r}, 32'h2);
`else
        chk("rdA_data", d, 32'hDEADBEEF);
        chk("rdA_rresp", {30'b0, r}, 32'h0);
`endif

        // Read/write collision on the same word
        do_write(32'h10, 32'hAAAA5555, 4'hF, r);
        araddr = 32'h10; arvalid = 1'b1;
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("coll_rvalid", {31'b0, rvalid}, 32'h1);
        chk("coll_rdata_old", rdata, 32'hAAAA5555);
        chk("coll_bvalid", {31'b0, bvalid}, 32'h1);
        rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        rready = 1'b0; bready = 1'b0;
        do_read(32'h10, d, r);
        chk("coll_rdata_new", d, 32'h12345678);

        // Read response back-pressure
        araddr = 32'h8; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", {31'b0, rvalid}, 32'h1);
            chk("stall_rdata", rdata, 32'hDEADBEEF);
            chk("stall_rresp", {30'b0, rresp}, 32'h0);
            chk("stall_arready", {31'b0, arready}, 32'h0);
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk("stall_rvalid_clear", {31'b0, rvalid}, 32'h0);

        // Write response back-pressure, then reset during W_RESP
        send_aw_w(32'h0, 32'h55AA55AA, 4'hF);
        for (int i = 0; i < 3; i++) begin
            chk("bstall_bvalid", {31'b0, bvalid}, 32'h1);
            chk("bstall_awready", {31'b0, awready}, 32'h0);
            chk("bstall_wready", {31'b0, wready}, 32'h0);
            @(negedge aclk);
        end
        #2 areset_n = 1'b0;
        #1;
        chk("async_rst_bvalid", {31'b0, bvalid}, 32'h0);
        chk("async_rst_awready", {31'b0, awready}, 32'h0);
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        do_read(32'h0, d, r);
        chk("rst_rd0_data", d, 32'h0);
        chk("rst_rd0_rresp", {30'b0, r}, 32'h0);
        do_read(32'h8, d, r);
        chk("rst_rd8_data", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
